// File: rtl/apu_pkg.sv
// ---------------------------------------------------------------------------
// apu_pkg
// Definitions shared by the sound-effect scheduler and its priority encoder.
//   NUM_REQ   : number of game-logic requesters.
//   ch_code_e : 2-bit APU channel codes used in the CH_MAP parameter.
//   state_e   : scheduler FSM state encodings.
// ---------------------------------------------------------------------------
package apu_pkg;

   localparam int NUM_REQ = 4;

   typedef enum logic [1:0] {
      CH_SAW    = 2'd0,
      CH_SQUARE = 2'd1,
      CH_NOISE  = 2'd2,
      CH_NONE   = 2'd3   // reserved: requester mapped here never triggers
   } ch_code_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_PLAYING = 2'd2
   } state_e;

endpackage

// File: rtl/sfx_priority_enc.sv
// ---------------------------------------------------------------------------
// sfx_priority_enc
// Combinational fixed-priority encoder over the registered pending requests.
// Index 0 is the highest priority.
// Ports:
//   pending   in  [3:0] latched request bits
//   active_id in  [1:0] requester currently owning the scheduler
//   sel       out [1:0] lowest set index of pending (0 when none set)
//   any       out       at least one pending bit set
//   preempt   out       a pending request outranks active_id
// ---------------------------------------------------------------------------
module sfx_priority_enc
   import apu_pkg::*;
(
   input  logic [NUM_REQ-1:0] pending,
   input  logic [1:0]         active_id,
   output logic [1:0]         sel,
   output logic               any,
   output logic               preempt
);

   always_comb begin
      sel     = 2'd0;
      any     = |pending;
      preempt = 1'b0;
      // Scan high to low so the lowest set index is the one left in sel.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (pending[i]) begin
            sel = 2'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pending[i] && (2'(i) < active_id)) begin
            preempt = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sfx_scheduler.sv
// ---------------------------------------------------------------------------
// sfx_scheduler
// Latches one-cycle sound-effect requests from four game-logic sources,
// grants them by fixed priority (req[0] highest), pulses the mapped APU
// trigger for one cycle and then holds the sound for HOLD_FRAMES frame ticks.
// A higher-priority request pre-empts the sound that is playing.
// Parameters:
//   CH_MAP      2-bit channel code per requester, packed {req3,req2,req1,req0}
//               (0 saw, 1 square, 2 noise, 3 none)
//   HOLD_FRAMES frame ticks a granted sound owns the scheduler (1..15)
// Ports:
//   clk            in      system clock
//   reset          in      asynchronous active-high reset
//   frame_tick     in      one-cycle pulse per video frame
//   req            in  [3] request pulses, req[0] highest priority
//   saw_trigger    out     one-cycle pulse to APU saw channel
//   square_trigger out     one-cycle pulse to APU square channel
//   noise_trigger  out     one-cycle pulse to APU noise channel
//   busy           out     high while in ISSUE or PLAYING
//   active_id      out [2] index of the last granted requester
// ---------------------------------------------------------------------------
module sfx_scheduler
   import apu_pkg::*;
#(
   parameter logic [7:0] CH_MAP      = 8'b01_00_01_10,
   parameter int         HOLD_FRAMES = 6
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic [NUM_REQ-1:0] req,
   output logic               saw_trigger,
   output logic               square_trigger,
   output logic               noise_trigger,
   output logic               busy,
   output logic [1:0]         active_id
);

   state_e               state_q,     state_d;
   logic [NUM_REQ-1:0]   pending_q,   pending_d;
   logic [NUM_REQ-1:0]   pending_clr;
   logic [1:0]           active_id_q, active_id_d;
   logic [3:0]           hold_cnt_q,  hold_cnt_d;
   logic                 saw_q,       saw_d;
   logic                 square_q,    square_d;
   logic                 noise_q,     noise_d;
   logic                 busy_q,      busy_d;

   logic [1:0]           sel;
   logic                 any;
   logic                 preempt;
   ch_code_e             active_ch;

   sfx_priority_enc u_prio (
      .pending   (pending_q),
      .active_id (active_id_q),
      .sel       (sel),
      .any       (any),
      .preempt   (preempt)
   );

   assign active_ch = ch_code_e'(CH_MAP[{active_id_q, 1'b0} +: 2]);

   always_comb begin
      state_d     = state_q;
      active_id_d = active_id_q;
      hold_cnt_d  = hold_cnt_q;
      pending_clr = '0;
      saw_d       = 1'b0;
      square_d    = 1'b0;
      noise_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (any) begin
               state_d          = ST_ISSUE;
               active_id_d      = sel;
               pending_clr[sel] = 1'b1;
            end
         end

         ST_ISSUE: begin
            // frame_tick is deliberately ignored here; the hold starts fresh.
            case (active_ch)
               CH_SAW:    saw_d    = 1'b1;
               CH_SQUARE: square_d = 1'b1;
               CH_NOISE:  noise_d  = 1'b1;
               default:   ;
            endcase
            hold_cnt_d = 4'(HOLD_FRAMES);
            state_d    = ST_PLAYING;
         end

         ST_PLAYING: begin
            // Pre-emption outranks expiry when both occur in one cycle.
            if (preempt) begin
               state_d          = ST_ISSUE;
               active_id_d      = sel;
               pending_clr[sel] = 1'b1;
            end else if (frame_tick) begin
               hold_cnt_d = hold_cnt_q - 4'd1;
               if (hold_cnt_q == 4'd1) begin
                  state_d = ST_IDLE;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // A new request arriving on the grant edge survives the clear.
      pending_d = (pending_q & ~pending_clr) | req;
      busy_d    = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         pending_q   <= '0;
         active_id_q <= 2'd0;
         hold_cnt_q  <= 4'd0;
         saw_q       <= 1'b0;
         square_q    <= 1'b0;
         noise_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         active_id_q <= active_id_d;
         hold_cnt_q  <= hold_cnt_d;
         saw_q       <= saw_d;
         square_q    <= square_d;
         noise_q     <= noise_d;
         busy_q      <= busy_d;
      end
   end

   assign saw_trigger    = saw_q;
   assign square_trigger = square_q;
   assign noise_trigger  = noise_q;
   assign busy           = busy_q;
   assign active_id      = active_id_q;

endmodule
